// File: rtl/can_bit_stuffer_if.sv
// Unstuffed frame bit stream from the frame/CRC generator into the bit stuffer.
// The master drives the bit and its qualifiers; the stuffer returns in_ready.
interface can_bit_stuffer_if;
  logic in_bit;
  logic in_valid;
  logic in_stuff_en;
  logic in_last;
  logic in_ready;

  modport master (
    output in_bit,
    output in_valid,
    output in_stuff_en,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_bit,
    input  in_valid,
    input  in_stuff_en,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/can_bit_stuffer.sv
// CAN transmit bit stuffer: inserts a complementary bit after STUFF_LEN identical
// bits inside the stuffing region and drives the serial TX bit (recessive when idle).
module can_bit_stuffer #(
  parameter  int STUFF_LEN = 5,
  localparam int CNT_W     = $clog2(STUFF_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_tick,
  can_bit_stuffer_if.slave     in_if,
  output logic                 tx_bit,
  output logic                 tx_active,
  output logic                 stuff_inserted,
  output logic                 frame_done,
  output logic                 err_underrun
);

  typedef enum logic [1:0] {IDLE, DATA, STUFF, TAIL} state_t;

  localparam logic [CNT_W-1:0] STUFF_CNT = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_bit_q, last_bit_d;
  logic             last_pending_q, last_pending_d;
  logic             tx_bit_q, tx_bit_d;
  logic             tx_active_q, tx_active_d;
  logic             stuff_inserted_q, stuff_inserted_d;
  logic             frame_done_q, frame_done_d;
  logic             err_underrun_q, err_underrun_d;
  logic             in_ready_w;
  logic             xfer;
  logic [CNT_W-1:0] run_next;

  assign in_ready_w     = bit_tick && (state_q == IDLE || state_q == DATA);
  assign in_if.in_ready = in_ready_w;
  assign xfer           = in_if.in_valid && in_ready_w;

  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    last_bit_d       = last_bit_q;
    last_pending_d   = last_pending_q;
    tx_bit_d         = tx_bit_q;
    tx_active_d      = tx_active_q;
    stuff_inserted_d = 1'b0;
    frame_done_d     = 1'b0;
    err_underrun_d   = 1'b0;
    run_next         = '0;

    if (xfer) begin
      // Bits outside the stuffing region break any run, so the count restarts at 0.
      if (!in_if.in_stuff_en)
        run_next = '0;
      else if (in_if.in_bit == last_bit_q && count_q != '0)
        run_next = count_q + ONE_CNT;
      else
        run_next = ONE_CNT;

      tx_bit_d    = in_if.in_bit;
      tx_active_d = 1'b1;
      count_d     = run_next;
      last_bit_d  = in_if.in_bit;

      if (run_next == STUFF_CNT) begin
        state_d        = STUFF;
        last_pending_d = in_if.in_last;
      end else if (in_if.in_last) begin
        state_d = TAIL;
      end else begin
        state_d = DATA;
      end
    end else if (bit_tick) begin
      case (state_q)
        DATA: begin
          err_underrun_d = 1'b1;
          tx_bit_d       = 1'b1;
          tx_active_d    = 1'b0;
          count_d        = '0;
          state_d        = IDLE;
        end
        STUFF: begin
          // The stuff bit itself opens the next run.
          tx_bit_d         = ~last_bit_q;
          stuff_inserted_d = 1'b1;
          count_d          = ONE_CNT;
          last_bit_d       = ~last_bit_q;
          state_d          = last_pending_q ? TAIL : DATA;
        end
        TAIL: begin
          tx_bit_d     = 1'b1;
          tx_active_d  = 1'b0;
          frame_done_d = 1'b1;
          count_d      = '0;
          last_bit_d   = 1'b1;
          state_d      = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      count_q          <= '0;
      last_bit_q       <= 1'b1;
      last_pending_q   <= 1'b0;
      tx_bit_q         <= 1'b1;
      tx_active_q      <= 1'b0;
      stuff_inserted_q <= 1'b0;
      frame_done_q     <= 1'b0;
      err_underrun_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      last_bit_q       <= last_bit_d;
      last_pending_q   <= last_pending_d;
      tx_bit_q         <= tx_bit_d;
      tx_active_q      <= tx_active_d;
      stuff_inserted_q <= stuff_inserted_d;
      frame_done_q     <= frame_done_d;
      err_underrun_q   <= err_underrun_d;
    end
  end

  assign tx_bit         = tx_bit_q;
  assign tx_active      = tx_active_q;
  assign stuff_inserted = stuff_inserted_q;
  assign frame_done     = frame_done_q;
  assign err_underrun   = err_underrun_q;

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Directed bench for can_bit_stuffer: each step presents one bit-time tick and
// checks ready, TX bit and pulses against hand-computed values.
module tb_can_bit_stuffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bit_tick = 1'b0;
  logic tx_bit, tx_active, stuff_inserted, frame_done, err_underrun;
  int   checks = 0;
  int   errors = 0;

  can_bit_stuffer_if bus ();

  can_bit_stuffer #(.STUFF_LEN(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .bit_tick       (bit_tick),
    .in_if          (bus),
    .tx_bit         (tx_bit),
    .tx_active      (tx_active),
    .stuff_inserted (stuff_inserted),
    .frame_done     (frame_done),
    .err_underrun   (err_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One tick: drive inputs, check ready, clock, check outputs, then a non-tick gap cycle.
  task automatic step(input string tag, input logic b, input logic v, input logic se,
                      input logic l, input logic rdy, input logic tx, input logic act,
                      input logic st, input logic dn, input logic er);
    @(negedge clk);
    bus.in_bit      = b;
    bus.in_valid    = v;
    bus.in_stuff_en = se;
    bus.in_last     = l;
    bit_tick        = 1'b1;
    #1;
    chk($sformatf("%s.rdy", tag), {7'd0, bus.in_ready}, {7'd0, rdy});
    @(posedge clk);
    #1;
    bit_tick = 1'b0;
    chk($sformatf("%s.tx", tag), {7'd0, tx_bit}, {7'd0, tx});
    chk($sformatf("%s.act", tag), {7'd0, tx_active}, {7'd0, act});
    chk($sformatf("%s.pulses", tag), {5'd0, stuff_inserted, frame_done, err_underrun},
        {5'd0, st, dn, er});
    $display("step %s in=%0b v=%0b se=%0b last=%0b tx=%0b act=%0b stuff=%0b done=%0b err=%0b",
             tag, b, v, se, l, tx_bit, tx_active, stuff_inserted, frame_done, err_underrun);
    @(posedge clk);
    #1;
    chk($sformatf("%s.gap_pulses", tag), {5'd0, stuff_inserted, frame_done, err_underrun}, 8'd0);
    chk($sformatf("%s.gap_tx", tag), {7'd0, tx_bit}, {7'd0, tx});
  endtask

  initial begin
    bus.in_bit      = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_stuff_en = 1'b0;
    bus.in_last     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.tx", {7'd0, tx_bit}, 8'd1);
    chk("reset.act", {7'd0, tx_active}, 8'd0);
    chk("reset.pulses", {5'd0, stuff_inserted, frame_done, err_underrun}, 8'd0);
    chk("reset.rdy_no_tick", {7'd0, bus.in_ready}, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    step("idle", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

    // 0,0,0,0,0,1(last): stuff after fifth 0, done on eighth tick
    for (int i = 0; i < 5; i++) step($sformatf("a%0d", i), 0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    step("a_stuff", 1, 1, 1, 1, 0, 1, 1, 1, 0, 0);
    step("a_last", 1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
    step("a_tail", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    step("a_idle", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

    // ten 0s: 00000 1 00000 1, trailing stuff before frame_done
    for (int i = 0; i < 5; i++) step($sformatf("b%0d", i), 0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    step("b_stuff1", 0, 1, 1, 0, 0, 1, 1, 1, 0, 0);
    for (int i = 5; i < 9; i++) step($sformatf("b%0d", i), 0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    step("b9_last", 0, 1, 1, 1, 1, 0, 1, 0, 0, 0);
    step("b_stuff2", 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    step("b_tail", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);

    // stuff bit opens a new run: 00000 1(s) 1111(last) 0(s)
    for (int i = 0; i < 5; i++) step($sformatf("c%0d", i), 0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    step("c_stuff1", 1, 1, 1, 0, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step($sformatf("c1_%0d", i), 1, 1, 1, 0, 1, 1, 1, 0, 0, 0);
    step("c_last", 1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
    step("c_stuff2", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step("c_tail", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);

    // outside the stuffing region: eight 1s then eight 0s pass unchanged
    for (int i = 0; i < 16; i++)
      step($sformatf("d%0d", i), (i < 8), 1, 0, (i == 15), 1, (i < 8), 1, 0, 0, 0);
    step("d_tail", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);

    // 0000 in region, then 0 outside: run cleared, no stuff
    for (int i = 0; i < 4; i++) step($sformatf("e%0d", i), 0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    step("e_out", 0, 1, 0, 1, 1, 0, 1, 0, 0, 0);
    step("e_tail", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);

    // stuff owed at region end is still sent before the first non-region bit
    for (int i = 0; i < 5; i++) step($sformatf("f%0d", i), 0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    step("f_stuff", 0, 1, 0, 1, 0, 1, 1, 1, 0, 0);
    step("f_out", 0, 1, 0, 1, 1, 0, 1, 0, 0, 0);
    step("f_tail", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);

    // underrun after three bits, then a new frame on the next tick
    step("g0", 1, 1, 1, 0, 1, 1, 1, 0, 0, 0);
    step("g1", 0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    step("g2", 1, 1, 1, 0, 1, 1, 1, 0, 0, 0);
    step("g_underrun", 0, 0, 1, 0, 1, 1, 0, 0, 0, 1);
    step("g_new", 0, 1, 1, 1, 1, 0, 1, 0, 0, 0);
    step("g_tail", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);

    // asynchronous reset mid-frame while a dominant bit is on the line
    step("h0", 0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("h_rst.tx", {7'd0, tx_bit}, 8'd1);
    chk("h_rst.act", {7'd0, tx_active}, 8'd0);
    chk("h_rst.pulses", {5'd0, stuff_inserted, frame_done, err_underrun}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    step("h_idle", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/can_bit_stuffer.md
Name: can_bit_stuffer

Overview:
- Sits directly downstream of the CAN frame/CRC generator and upstream of the transmit pin driver.
- Accepts the unstuffed frame bitstream (SOF through EOF) one bit per bit time over a valid/ready handshake.
- Inserts a complementary stuff bit after STUFF_LEN consecutive identical bits, but only inside the stuffing region (SOF..CRC sequence). Drives the serial TX bit, recessive (1) when idle.

Parameters:
- STUFF_LEN, 5, number of consecutive identical bits that triggers a stuff bit; legal range 2..15.
- CNT_W, $clog2(STUFF_LEN+1), width of the run-length counter; derived, not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- bit_tick  input  1  one-cycle bit-time enable from bit timing logic; all bit-level actions happen only on cycles with bit_tick=1
- in_bit  input  1  next unstuffed frame bit
- in_valid  input  1  in_bit is valid
- in_stuff_en  input  1  in_bit is in the stuffing region; sampled with in_bit
- in_last  input  1  in_bit is the final bit of the frame; sampled with in_bit
- in_ready  output  1  block accepts a bit this cycle
- tx_bit  output  1  serial CAN TX bit; 1 = recessive
- tx_active  output  1  frame transmission in progress
- stuff_inserted  output  1  one-cycle pulse when a stuff bit is driven
- frame_done  output  1  one-cycle pulse at the end of the frame
- err_underrun  output  1  one-cycle pulse when input is starved mid-frame

Behaviour:
- Reset (rst=0, asynchronous): tx_bit=1, tx_active=0, stuff_inserted=0, frame_done=0, err_underrun=0, run counter=0, last_bit=1, state=IDLE, stuff_pending=0, last_pending=0.
- States:
  - IDLE: no frame.
  - DATA: frame bits being sent.
  - STUFF: stuff bit owed on the next tick.
  - TAIL: final bit on the line, waiting one bit time.
- in_ready is combinational: in_ready = bit_tick && (state==IDLE || state==DATA).
- Transfer occurs when in_valid && in_ready.
- On transfer:
  - tx_bit <= in_bit on that same clock edge (one-cycle latency).
  - tx_active <= 1.
- Run counting on transfer:
  - If in_stuff_en=1 and (in_bit==last_bit and count>0): count <= count+1.
  - Else if in_stuff_en=1: count <= 1.
  - If in_stuff_en=0: count <= 0 and no stuffing is possible.
  - last_bit <= in_bit in all cases.
- State after transfer:
  - If the new count equals STUFF_LEN: go to STUFF and latch last_pending <= in_last.
  - Else if in_last: go to TAIL.
  - Else: go to DATA.
- STUFF, on bit_tick:
  - tx_bit <= ~last_bit; stuff_inserted pulses; count <= 1; last_bit <= ~last_bit.
  - The stuff bit counts toward the next run.
  - Next state is TAIL if last_pending=1, else DATA. in_ready is 0 during this tick.
- TAIL, on bit_tick:
  - tx_bit <= 1, tx_active <= 0, frame_done pulses.
  - count <= 0, last_bit <= 1, state <= IDLE.
- IDLE with bit_tick and no in_valid: no change; tx_bit stays 1.
- Underrun (DATA, bit_tick, in_valid=0):
  - err_underrun pulses; tx_bit <= 1; tx_active <= 0.
  - count <= 0; state <= IDLE; no frame_done.
- in_valid changing between ticks is ignored; only tick cycles matter.
- When in_stuff_en falls 1->0, the count is cleared with the first non-stuff-region bit. A stuff bit owed from the last region bit (end of CRC) is still inserted before that bit.
- Reset asserted mid-frame aborts immediately to the reset values; no pulses are generated.

Test Plan:
- Reset mid-frame (rst=0 while tx_bit=0 in DATA) -> tx_bit=1 and tx_active=0 asynchronously; IDLE after release; no frame_done.
- stuff_en=1, input 0,0,0,0,0,1(last) -> tx 0,0,0,0,0,1(stuff),1, then idle 1. One stuff_inserted pulse, on the 6th tick. frame_done on the 8th tick.
- stuff_en=1, ten 0s (last on 10th) -> tx 00000 1 00000 1. Two stuff pulses; the trailing stuff bit is sent before frame_done.
- Stuff bit starts a new run: input 0,0,0,0,0,1,1,1,1(last) -> tx 0,0,0,0,0,1(s),1,1,1,1,0(s). Two stuff pulses.
- stuff_en=0, eight 1s then eight 0s -> output identical to input, zero stuff pulses. Also, 0000 with stuff_en=1 followed by 0 with stuff_en=0 -> no stuff (count cleared).
- Underrun: drop in_valid after 3 bits mid-frame -> err_underrun pulses on that tick, tx_bit=1, IDLE, no frame_done. A next frame with in_valid=1 is accepted on the following tick.
